// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the simple register bus initiator.
package reg_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } bus_state_e;

    // Wide enough for the largest legal RD_WAIT / WR_GAP (15).
    localparam int WAIT_CNT_W = 4;

    // Default bus widths, matching the regfile generator.
    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_WDATA_WIDTH = 32;
    localparam int DEF_RDATA_WIDTH = 32;

endpackage

// File: rtl/reg_bus_master.sv
// Single-outstanding initiator for the simple register bus. Takes one request
// on a valid/ready port, runs one bus access, and returns read data or a write
// completion on a valid/ready response port.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | ready for a request; bus quiet, reg_addr holds last value
//   ACCESS | one-cycle reg_en strobe with the captured request
//   WAIT   | down-counter runs; read data sampled when count reaches 1
//   RESP   | response presented until the consumer accepts it
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WDATA_WIDTH = DEF_WDATA_WIDTH,
    parameter int RDATA_WIDTH = DEF_RDATA_WIDTH,
    parameter int RD_WAIT     = 1,
    parameter int WR_GAP      = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [WDATA_WIDTH-1:0] req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_we,
    output logic [RDATA_WIDTH-1:0] rsp_rdata,
    output logic                   reg_en,
    output logic                   reg_we,
    output logic [ADDR_WIDTH-1:0]  reg_addr,
    output logic [WDATA_WIDTH-1:0] reg_wdata,
    input  logic [RDATA_WIDTH-1:0] reg_rdata
);

    if (RD_WAIT < 1 || RD_WAIT > 15) begin : g_bad_rd_wait
        $error("reg_bus_master: RD_WAIT must be within 1..15");
    end
    if (WR_GAP < 1 || WR_GAP > 15) begin : g_bad_wr_gap
        $error("reg_bus_master: WR_GAP must be within 1..15");
    end

    localparam logic [WAIT_CNT_W-1:0] RD_LOAD = WAIT_CNT_W'(RD_WAIT);
    localparam logic [WAIT_CNT_W-1:0] WR_LOAD = WAIT_CNT_W'(WR_GAP);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE = WAIT_CNT_W'(1);

    bus_state_e             state;
    bus_state_e             state_next;
    logic [WAIT_CNT_W-1:0]  cnt;
    logic [WAIT_CNT_W-1:0]  cnt_next;
    logic                   capture;
    logic                   sample;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [WDATA_WIDTH-1:0] wdata_q;
    logic [RDATA_WIDTH-1:0] rdata_q;

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state, counter load/decrement, capture and sample strobes.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        sample     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    capture    = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                cnt_next   = we_q ? WR_LOAD : RD_LOAD;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt == CNT_ONE) begin
                    sample     = 1'b1;
                    cnt_next   = '0;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Request holding registers; write data only moves on a write capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (capture) begin
            we_q   <= req_we;
            addr_q <= req_addr;
            if (req_we) begin
                wdata_q <= req_wdata;
            end
        end
    end

    // Response data register; writes complete with zero data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (sample) begin
            rdata_q <= we_q ? '0 : reg_rdata;
        end
    end

    // IDLE is also the reset state, so req_ready is qualified by reset_n to
    // keep it low while reset is asserted.
    assign req_ready = (state == IDLE) && reset_n;
    assign reg_en    = (state == ACCESS);
    assign reg_we    = (state == ACCESS) && we_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign rsp_valid = (state == RESP);
    assign rsp_we    = (state == RESP) && we_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Self-checking bench for reg_bus_master against a small regfile model.
module tb_reg_bus_master;

    localparam int AW = 32;
    localparam int WW = 32;
    localparam int RW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [WW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_we;
    logic [RW-1:0] rsp_rdata;
    logic          reg_en;
    logic          reg_we;
    logic [AW-1:0] reg_addr;
    logic [WW-1:0] reg_wdata;
    logic [RW-1:0] reg_rdata;

    always #5 clk = ~clk;

    reg_bus_master #(
        .ADDR_WIDTH(AW), .WDATA_WIDTH(WW), .RDATA_WIDTH(RW),
        .RD_WAIT(1), .WR_GAP(2)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata),
        .reg_en(reg_en), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
    );

    // Regfile model: registered write, combinational read; 0x4 is unmapped.
    logic [31:0] rf0 = '0;
    logic [31:0] rf8 = '0;
    always @(posedge clk) begin
        if (reg_en && reg_we) begin
            if (reg_addr == 32'h0) rf0 <= reg_wdata;
            if (reg_addr == 32'h8) rf8 <= reg_wdata;
        end
    end
    assign reg_rdata = (reg_addr == 32'h0) ? rf0 :
                       (reg_addr == 32'h8) ? rf8 : 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] rdata;
    } rsp_t;
    rsp_t exp_q[$];

    int cyc = 0;
    int en_pulses = 0;
    int last_en_cyc = 0;
    int prev_en_cyc = 0;

    always @(posedge clk) cyc++;

    // Response scoreboard and bus activity monitor.
    always @(negedge clk) begin
        rsp_t e;
        if (reset_n) begin
            if (reg_en) begin
                en_pulses++;
                prev_en_cyc = last_en_cyc;
                last_en_cyc = cyc;
            end
            if (rsp_valid) check("no_reg_en_in_resp", reg_en, 1'b0);
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rsp_we", rsp_we, e.we);
                    check("rsp_rdata", rsp_rdata, e.rdata);
                end
            end
        end
    end

    // Drive one request from posedge+1, push its expected response, wait for accept.
    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata);
        rsp_t e;
        int t;
        e.we    = we;
        e.rdata = we ? 32'h0 : exp_rdata;
        exp_q.push_back(e);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("req_accept", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_responses", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[8];

    initial begin
        int en_before;
        int t;
        rsp_t e;

        vecs[0] = '{1'b1, 32'h0, 32'hA5A5_5A5A, 32'h0};
        vecs[1] = '{1'b0, 32'h0, 32'h0,         32'hA5A5_5A5A};
        vecs[2] = '{1'b0, 32'h4, 32'h0,         32'h0};
        vecs[3] = '{1'b1, 32'h8, 32'hDEAD_BEEF, 32'h0};
        vecs[4] = '{1'b0, 32'h8, 32'h0,         32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 32'h0, 32'h1234_5678, 32'h0};
        vecs[6] = '{1'b0, 32'h0, 32'h0,         32'h1234_5678};
        vecs[7] = '{1'b0, 32'h8, 32'h0,         32'hDEAD_BEEF};

        // Reset state.
        #12;
        check("reset_outputs_zero",
              |{req_ready, rsp_valid, rsp_we, rsp_rdata, reg_en, reg_we, reg_addr, reg_wdata}, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1'b1);
        check("no_rsp_after_reset", rsp_valid, 1'b0);
        @(posedge clk);
        #1;

        // Table of single transactions, each fully drained.
        for (int i = 0; i < 8; i++) begin
            en_before = en_pulses;
            send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
            drain();
            check("one_reg_en_per_req", en_pulses - en_before, 1);
        end

        // Read latency with RD_WAIT=1 and rsp_ready=1.
        e.we = 1'b0;
        e.rdata = 32'h1234_5678;
        exp_q.push_back(e);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("lat_n_reg_en", reg_en, 1'b1);
        check("lat_n_reg_we", reg_we, 1'b0);
        check("lat_n_req_ready", req_ready, 1'b0);
        @(posedge clk);
        #1;
        check("lat_n1_reg_en", reg_en, 1'b0);
        check("lat_n1_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk);
        #1;
        check("lat_n2_rsp_valid", rsp_valid, 1'b1);
        check("lat_n2_rsp_rdata", rsp_rdata, 32'h1234_5678);
        @(posedge clk);
        #1;
        check("lat_n3_rsp_valid", rsp_valid, 1'b0);
        check("lat_n3_req_ready", req_ready, 1'b1);
        drain();

        // Response back-pressure for 10 cycles.
        rsp_ready = 1'b0;
        send(1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF);
        t = 0;
        while (!rsp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("stall_rsp_seen", rsp_valid, 1'b1);
        en_before = en_pulses;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", rsp_valid, 1'b1);
            check("stall_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
            check("stall_req_ready", req_ready, 1'b0);
        end
        check("stall_no_reg_en", en_pulses - en_before, 0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drain();

        // Back-to-back write then read with req_valid held high.
        en_before = en_pulses;
        send(1'b1, 32'h0, 32'hCAFE_F00D, 32'h0);
        send(1'b0, 32'h0, 32'h0, 32'hCAFE_F00D);
        drain();
        check("b2b_reg_en_count", en_pulses - en_before, 2);
        check("b2b_idle_gap", last_en_cyc - prev_en_cyc - 1, 4);

        // Reset asserted during WAIT of a read.
        send(1'b0, 32'h0, 32'h0, 32'hCAFE_F00D);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        check("midreset_outputs_zero",
              |{req_ready, rsp_valid, rsp_we, rsp_rdata, reg_en, reg_we, reg_addr, reg_wdata}, 1'b0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(negedge clk);
        check("midreset_ready", req_ready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("midreset_no_rsp", rsp_valid, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;

        // Recovery after reset.
        en_before = en_pulses;
        send(1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF);
        drain();
        check("post_reset_reg_en", en_pulses - en_before, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
